// File: rtl/key_dir_pkg.sv
// Shared types and helpers for the W/A/S/D direction queue.
// Keycode constants, direction enum and encode/decode functions.
package key_dir_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_U = 2'b11
  } dir_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_dec_t;

  function automatic key_dec_t key_to_dir(
    input logic [7:0] key
  );
    key_dec_t r;
    r = '{valid: 1'b0, dir: DIR_L};
    unique case (1'b1)
      key == KEY_A: r = '{valid: 1'b1, dir: DIR_L};
      key == KEY_D: r = '{valid: 1'b1, dir: DIR_R};
      key == KEY_S: r = '{valid: 1'b1, dir: DIR_D};
      key == KEY_W: r = '{valid: 1'b1, dir: DIR_U};
      default: r = '{valid: 1'b0, dir: DIR_L};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] dir_to_key(
    input dir_t d
  );
    logic [7:0] k;
    case (d)
      DIR_L:   k = KEY_A;
      DIR_R:   k = KEY_D;
      DIR_D:   k = KEY_S;
      default: k = KEY_W;
    endcase
    return k;
  endfunction

  // L<->R and D<->U differ only in the low bit.
  function automatic dir_t opposite(
    input dir_t d
  );
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Circular buffer of direction commands, DEPTH entries of dir_t.
// Exposes head for popping and tail for duplicate filtering.
import key_dir_pkg::*;

module dir_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  dir_t          data,
  output dir_t          head,
  output dir_t          tail,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  dir_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  assign head  = mem[rd_ptr];
  assign tail  = mem[wr_ptr - AW'(1)];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Full push+pop is safe: head is read before the slot is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DIR_L;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_dir_queue.sv
// Keycode stream to queued direction commands, one released per frame.
// Define REVERSE_REJECT_EN to drop presses opposite the reference dir.
import key_dir_pkg::*;

module key_dir_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    keycode_in,
  input  logic          frame_tick,
  output logic [7:0]    keycode_out,
  output logic [1:0]    dir_out,
  output logic          dir_valid,
  output logic [CW-1:0] q_count,
  output logic          overflow
);

  logic [7:0] key_r;
  logic [7:0] prev;
  dir_t       cur_dir;

  key_dec_t   dec;
  logic       press;
  logic       ref_ok;
  dir_t       ref_dir;
  logic       dup;
  logic       rev;
  logic       accept;
  logic       push;
  logic       pop;
  logic       drop;

  dir_t       head;
  dir_t       tail;
  logic       full;
  logic       empty;

  dir_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .data  (dec.dir),
    .head  (head),
    .tail  (tail),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // Reference is taken before any pop in this cycle.
  always_comb begin
    dec     = key_to_dir(key_r);
    press   = dec.valid && (key_r != prev);
    ref_ok  = !empty || dir_valid;
    ref_dir = empty ? cur_dir : tail;
    dup     = ref_ok && (dec.dir == ref_dir);
`ifdef REVERSE_REJECT_EN
    rev     = ref_ok && (dec.dir == opposite(ref_dir));
`else
    rev     = 1'b0;
`endif
    accept  = press && !dup && !rev;
    pop     = frame_tick && !empty;
    push    = accept && (!full || pop);
    drop    = accept && full && !pop;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_r       <= 8'h00;
      prev        <= 8'h00;
      cur_dir     <= DIR_L;
      dir_valid   <= 1'b0;
      keycode_out <= 8'h00;
      overflow    <= 1'b0;
    end else begin
      key_r    <= keycode_in;
      prev     <= key_r;
      overflow <= drop;
      if (pop) begin
        cur_dir     <= head;
        dir_valid   <= 1'b1;
        keycode_out <= dir_to_key(head);
      end
    end
  end

  assign dir_out = cur_dir;

endmodule

// File: tb/tb_key_dir_queue.sv
// Directed bench for key_dir_queue with a queue-based reference model.
// Honours REVERSE_REJECT_EN the same way the design does.
module tb_key_dir_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst;
  logic [7:0]    keycode_in;
  logic          frame_tick;
  logic [7:0]    keycode_out;
  logic [1:0]    dir_out;
  logic          dir_valid;
  logic [CW-1:0] q_count;
  logic          overflow;

  int checks;
  int errors;
  int ovf_total;

  key_dir_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .keycode_in  (keycode_in),
    .frame_tick  (frame_tick),
    .keycode_out (keycode_out),
    .dir_out     (dir_out),
    .dir_valid   (dir_valid),
    .q_count     (q_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of directions plus the two most
  // recent keycodes the design has seen.
  logic [7:0] m_key, m_prev, m_kout;
  logic [1:0] m_dir;
  bit         m_valid, m_ovf;
  logic [1:0] m_q[$];
  bit         ev, has_ref, ok, do_pop;
  logic [1:0] d, r;

  function automatic logic [7:0] enc(input logic [1:0] x);
    logic [7:0] t [4];
    t[0] = 8'h04; t[1] = 8'h07; t[2] = 8'h16; t[3] = 8'h1A;
    return t[x];
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_key = 0; m_prev = 0; m_kout = 0; m_dir = 0;
        m_valid = 0; m_ovf = 0;
        m_q.delete();
      end else begin
        ev = 1; d = 0;
        case (m_key)
          8'h04: d = 2'd0;
          8'h07: d = 2'd1;
          8'h16: d = 2'd2;
          8'h1A: d = 2'd3;
          default: ev = 0;
        endcase
        if (m_key == m_prev) ev = 0;
        has_ref = (m_q.size() > 0) || m_valid;
        r = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
        ok = ev && !(has_ref && d == r);
`ifdef REVERSE_REJECT_EN
        if (has_ref && d == {r[1], ~r[0]}) ok = 0;
`endif
        do_pop = frame_tick && (m_q.size() > 0);
        m_ovf = ok && (m_q.size() == DEPTH) && !do_pop;
        if (do_pop) begin
          m_dir = m_q.pop_front();
          m_valid = 1;
          m_kout = enc(m_dir);
        end
        if (ok && !m_ovf) m_q.push_back(d);
        m_prev = m_key;
        m_key = keycode_in;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("m_keycode_out", keycode_out, m_kout);
        chk("m_dir_out", dir_out, m_dir);
        chk("m_dir_valid", dir_valid, m_valid);
        chk("m_q_count", q_count, m_q.size());
        chk("m_overflow", overflow, m_ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && overflow) ovf_total <= ovf_total + 1;
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] k);
    keycode_in = k;
    nclk(2);
    keycode_in = 8'h00;
    nclk(2);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    nclk(1);
    frame_tick = 1'b0;
    nclk(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    nclk(2);
    rst = 1'b0;
    nclk(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  int base;

  initial begin
    checks = 0; errors = 0; ovf_total = 0;
    rst = 1'b1; keycode_in = 8'h00; frame_tick = 1'b0;
    nclk(3);
    rst = 1'b0;
    nclk(1);
    chk("rst_kout", keycode_out, 8'h00);
    chk("rst_dir", dir_out, 0);
    chk("rst_valid", dir_valid, 0);
    chk("rst_count", q_count, 0);
    chk("rst_ovf", overflow, 0);

    // Held key produces one push only
    keycode_in = 8'h07;
    nclk(10);
    keycode_in = 8'h00;
    nclk(2);
    chk("t1_count", q_count, 1);
    tick();
    chk("t1_kout", keycode_out, 8'h07);
    chk("t1_dir", dir_out, 1);
    chk("t1_valid", dir_valid, 1);
    chk("t1_count0", q_count, 0);

    // Queued turns released in order
    press(8'h1A);
    press(8'h04);
    press(8'h16);
    chk("t2_count", q_count, 3);
    tick(); chk("t2_k1", keycode_out, 8'h1A);
    tick(); chk("t2_k2", keycode_out, 8'h04);
    tick(); chk("t2_k3", keycode_out, 8'h16);
    tick(); chk("t2_hold", keycode_out, 8'h16);
    chk("t2_empty", q_count, 0);

    // Overflow on fifth distinct press
    do_reset();
    base = ovf_total;
    press(8'h1A); press(8'h04); press(8'h1A); press(8'h04); press(8'h1A);
    chk("t3_count", q_count, 4);
    chk("t3_ovf_pulses", ovf_total - base, 1);
    chk("t3_valid", dir_valid, 0);

    // Full queue, press lands in the tick cycle
    keycode_in = 8'h1A;
    nclk(1);
    frame_tick = 1'b1;
    nclk(1);
    frame_tick = 1'b0;
    keycode_in = 8'h00;
    nclk(2);
    chk("t4_count", q_count, 4);
    chk("t4_ovf_pulses", ovf_total - base, 1);
    chk("t4_kout", keycode_out, 8'h1A);
    chk("t4_dir", dir_out, 3);
    repeat (4) tick();
    chk("t4_drain", q_count, 0);
    chk("t4_last", keycode_out, 8'h1A);

    // Duplicate and reversal filtering
    press(8'h07);
    tick();
    chk("t5_dir", dir_out, 1);
    press(8'h07);
    chk("t5_dup", q_count, 0);
    press(8'h04);
`ifdef REVERSE_REJECT_EN
    chk("t5_rev", q_count, 0);
`else
    chk("t5_rev", q_count, 1);
`endif

    // Reset mid-frame with two entries queued
`ifdef REVERSE_REJECT_EN
    press(8'h1A);
    press(8'h04);
`else
    press(8'h1A);
`endif
    chk("t6_count", q_count, 2);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_kout", keycode_out, 8'h00);
    chk("t6_dir", dir_out, 0);
    chk("t6_valid", dir_valid, 0);
    chk("t6_count0", q_count, 0);
    nclk(1);
    rst = 1'b0;
    nclk(1);
    tick();
    chk("t6_tick_kout", keycode_out, 8'h00);
    chk("t6_tick_valid", dir_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
